// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory / write-back stage.
// Imported by the stage, its RAM and its interface.
package mem_wb_stage_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_IN  = 2'b10,
      WB_RD2 = 2'b11
   } wb_sel_e;

   typedef enum logic {
      OUT_RD2 = 1'b0,
      OUT_ALU = 1'b1
   } out_sel_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
// The pipeline side drives the M fields; the stage drives the W fields.
interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic              wr_en_regf_M;
   logic              wr_en_dmem_M;
   logic              rd_en_M;
   logic              out_port_sel_M;
   logic              is_ret_M;
   logic              mux_out_sel_M;
   logic [1:0]        mux_rdata_sel_M;
   logic [DATA_W-1:0] alu_out_M;
   logic [DATA_W-1:0] RD2_M;
   logic [DATA_W-1:0] IN_PORT_M;
   logic [1:0]        rd_M;
   logic [7:0]        mem_addr_M;
   logic [DATA_W-1:0] mem_wd_M;
   logic [1:0]        PC_Sel_M;

   logic [DATA_W-1:0] fwd_data_M;
   logic              wr_en_regf_W;
   logic [1:0]        rd_W;
   logic [DATA_W-1:0] wb_data_W;
   logic              ret_valid_W;
   logic [DATA_W-1:0] ret_pc_W;
   logic [1:0]        PC_Sel_W;
   logic [DATA_W-1:0] OUT_PORT;

   modport master (
      output wr_en_regf_M, wr_en_dmem_M, rd_en_M,
      output out_port_sel_M, is_ret_M, mux_out_sel_M,
      output mux_rdata_sel_M, alu_out_M, RD2_M, IN_PORT_M,
      output rd_M, mem_addr_M, mem_wd_M, PC_Sel_M,
      input  fwd_data_M, wr_en_regf_W, rd_W, wb_data_W,
      input  ret_valid_W, ret_pc_W, PC_Sel_W, OUT_PORT
   );

   modport slave (
      input  wr_en_regf_M, wr_en_dmem_M, rd_en_M,
      input  out_port_sel_M, is_ret_M, mux_out_sel_M,
      input  mux_rdata_sel_M, alu_out_M, RD2_M, IN_PORT_M,
      input  rd_M, mem_addr_M, mem_wd_M, PC_Sel_M,
      output fwd_data_M, wr_en_regf_W, rd_W, wb_data_W,
      output ret_valid_W, ret_pc_W, PC_Sel_W, OUT_PORT
   );

endinterface

// File: rtl/mem_wb_stage_dmem_sp.sv
// Single-port synchronous read-first data memory.
// Contents survive reset; only the read register clears.
module dmem_sp
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_d, rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[addr];
   end

   // rst_n gate drops a write on the edge reset asserts
   always_ff @(posedge clk) begin
      if (rst_n && we) mem[addr] <= wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: data memory, OUT port,
// write-back mux, RET target and M-stage forwarding.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   mem_wb_stage_if.slave bus
);

   logic [DATA_W-1:0] mem_q;

   logic              wr_en_d, wr_en_q;
   logic [1:0]        rd_d, rd_q;
   logic [1:0]        sel_d, sel_q;
   logic [DATA_W-1:0] alu_d, alu_q;
   logic [DATA_W-1:0] in_d, in_q;
   logic [DATA_W-1:0] rd2_d, rd2_q;
   logic [1:0]        pcs_d, pcs_q;
   logic              ret_d, ret_q;
   logic [DATA_W-1:0] out_d, out_q;
   logic [DATA_W-1:0] wb_data;

   dmem_sp #(.ADDR_W(ADDR_W)) u_dmem (
      .clk   (clk),
      .rst_n (reset),
      .we    (bus.wr_en_dmem_M),
      .re    (bus.rd_en_M | bus.is_ret_M),
      .addr  (bus.mem_addr_M[ADDR_W-1:0]),
      .wd    (bus.mem_wd_M),
      .rdata (mem_q)
   );

   always_comb begin
      wr_en_d = bus.wr_en_regf_M;
      rd_d    = bus.rd_M;
      sel_d   = bus.mux_rdata_sel_M;
      alu_d   = bus.alu_out_M;
      in_d    = bus.IN_PORT_M;
      rd2_d   = bus.RD2_M;
      pcs_d   = bus.PC_Sel_M;
      ret_d   = bus.is_ret_M;
      out_d   = out_q;
      if (bus.out_port_sel_M) begin
         out_d = (bus.mux_out_sel_M == OUT_ALU)
               ? bus.alu_out_M : bus.RD2_M;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_q <= 1'b0;
         rd_q    <= '0;
         sel_q   <= '0;
         alu_q   <= '0;
         in_q    <= '0;
         rd2_q   <= '0;
         pcs_q   <= '0;
         ret_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         wr_en_q <= wr_en_d;
         rd_q    <= rd_d;
         sel_q   <= sel_d;
         alu_q   <= alu_d;
         in_q    <= in_d;
         rd2_q   <= rd2_d;
         pcs_q   <= pcs_d;
         ret_q   <= ret_d;
         out_q   <= out_d;
      end
   end

   // mem_q is already one cycle late, so it lines up with the W fields
   always_comb begin
      wb_data = alu_q;
      unique case (sel_q)
         WB_ALU:  wb_data = alu_q;
         WB_MEM:  wb_data = mem_q;
         WB_IN:   wb_data = in_q;
         WB_RD2:  wb_data = rd2_q;
         default: wb_data = alu_q;
      endcase
   end

   assign bus.fwd_data_M   = bus.alu_out_M;
   assign bus.wr_en_regf_W = wr_en_q;
   assign bus.rd_W         = rd_q;
   assign bus.wb_data_W    = wb_data;
   assign bus.ret_valid_W  = ret_q;
   assign bus.ret_pc_W     = mem_q;
   assign bus.PC_Sel_W     = pcs_q;
   assign bus.OUT_PORT     = out_q;

endmodule
